// File: rtl/sccb_arb.sv
// rtl/sccb_arb.sv - round-robin arbiter sharing one SCCB/I2C byte master between two requesters
// Optional transaction watchdog enabled by defining SCCB_ARB_TIMEOUT_EN.
module sccb_arb #(
  parameter logic [19:0] TIMEOUT_CYC = 20'd500_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0_valid,
  input  logic       req0_rw,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ack,
  input  logic       req1_valid,
  input  logic       req1_rw,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ack,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       i2c_start,
  output logic       i2c_wr_en,
  output logic       i2c_rd_en,
  output logic [7:0] i2c_byte_addr,
  output logic [7:0] i2c_wr_data,
  input  logic       i2c_end,
  input  logic [7:0] i2c_rd_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t     state, state_nx;
  logic       hold_rw, hold_rw_nx;
  logic [7:0] hold_addr, hold_addr_nx;
  logic [7:0] hold_wdata, hold_wdata_nx;
  logic       gnt_id, gnt_id_nx;
  logic       rr_last, rr_last_nx;
  logic       win;

  logic       ack0_nx, ack1_nx, start_nx, err_nx;
  logic       busy_nx, wr_en_nx, rd_en_nx;
  logic [7:0] rdata_nx, addr_nx, wdata_nx;

`ifdef SCCB_ARB_TIMEOUT_EN
  logic [19:0] tmo_cnt, tmo_cnt_nx;
`else
  // Watchdog compiled out; the parameter stays so instantiations need not change.
  if (TIMEOUT_CYC == 20'd0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      hold_rw       <= 1'b0;
      hold_addr     <= 8'h00;
      hold_wdata    <= 8'h00;
      gnt_id        <= 1'b0;
      rr_last       <= 1'b1;
      req0_ack      <= 1'b0;
      req1_ack      <= 1'b0;
      rsp_rdata     <= 8'h00;
      rsp_err       <= 1'b0;
      i2c_start     <= 1'b0;
      i2c_wr_en     <= 1'b0;
      i2c_rd_en     <= 1'b0;
      i2c_byte_addr <= 8'h00;
      i2c_wr_data   <= 8'h00;
      busy          <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
      tmo_cnt       <= 20'd0;
`endif
    end else begin
      state         <= state_nx;
      hold_rw       <= hold_rw_nx;
      hold_addr     <= hold_addr_nx;
      hold_wdata    <= hold_wdata_nx;
      gnt_id        <= gnt_id_nx;
      rr_last       <= rr_last_nx;
      req0_ack      <= ack0_nx;
      req1_ack      <= ack1_nx;
      rsp_rdata     <= rdata_nx;
      rsp_err       <= err_nx;
      i2c_start     <= start_nx;
      i2c_wr_en     <= wr_en_nx;
      i2c_rd_en     <= rd_en_nx;
      i2c_byte_addr <= addr_nx;
      i2c_wr_data   <= wdata_nx;
      busy          <= busy_nx;
`ifdef SCCB_ARB_TIMEOUT_EN
      tmo_cnt       <= tmo_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx      = state;
    hold_rw_nx    = hold_rw;
    hold_addr_nx  = hold_addr;
    hold_wdata_nx = hold_wdata;
    gnt_id_nx     = gnt_id;
    rr_last_nx    = rr_last;
    ack0_nx       = 1'b0;
    ack1_nx       = 1'b0;
    start_nx      = 1'b0;
    rdata_nx      = rsp_rdata;
    err_nx        = rsp_err;
`ifdef SCCB_ARB_TIMEOUT_EN
    tmo_cnt_nx    = tmo_cnt;
`endif
    // On a tie the requester that did not win last time gets the bus.
    win = (req0_valid && req1_valid) ? ~rr_last : req1_valid;

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          hold_rw_nx    = win ? req1_rw    : req0_rw;
          hold_addr_nx  = win ? req1_addr  : req0_addr;
          hold_wdata_nx = win ? req1_wdata : req0_wdata;
          gnt_id_nx     = win;
          rr_last_nx    = win;
          start_nx      = 1'b1;
          state_nx      = START;
        end
      end
      START: begin
`ifdef SCCB_ARB_TIMEOUT_EN
        tmo_cnt_nx = 20'd0;
`endif
        state_nx = BUSY;
      end
      BUSY: begin
        if (i2c_end) begin
          rdata_nx = hold_rw ? i2c_rd_data : 8'h00;
          err_nx   = 1'b0;
          ack0_nx  = ~gnt_id;
          ack1_nx  = gnt_id;
          state_nx = DONE;
        end
`ifdef SCCB_ARB_TIMEOUT_EN
        else if (tmo_cnt == TIMEOUT_CYC - 20'd1) begin
          rdata_nx = 8'h00;
          err_nx   = 1'b1;
          ack0_nx  = ~gnt_id;
          ack1_nx  = gnt_id;
          state_nx = DONE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 20'd1;
        end
`endif
      end
      DONE: begin
        rdata_nx = 8'h00;
        err_nx   = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Master-side outputs follow the hold registers for the whole transaction.
    busy_nx  = (state_nx != IDLE);
    wr_en_nx = busy_nx & ~hold_rw_nx;
    rd_en_nx = busy_nx & hold_rw_nx;
    addr_nx  = busy_nx ? hold_addr_nx  : 8'h00;
    wdata_nx = busy_nx ? hold_wdata_nx : 8'h00;
  end

endmodule

// File: tb/tb_sccb_arb.sv
// tb/tb_sccb_arb.sv - directed vector table plus multi-cycle sequences for sccb_arb
module tb_sccb_arb;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       req0_valid, req0_rw, req1_valid, req1_rw;
  logic [7:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic       req0_ack, req1_ack;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       i2c_start, i2c_wr_en, i2c_rd_en;
  logic [7:0] i2c_byte_addr, i2c_wr_data;
  logic       i2c_end;
  logic [7:0] i2c_rd_data;
  logic       busy;

  int n_vec = 0;
  int n_mis = 0;
  int start_cnt = 0;
  int ack_log[$];

  always #10 sys_clk = ~sys_clk;

  sccb_arb #(.TIMEOUT_CYC(20'd100)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .i2c_start(i2c_start), .i2c_wr_en(i2c_wr_en), .i2c_rd_en(i2c_rd_en),
    .i2c_byte_addr(i2c_byte_addr), .i2c_wr_data(i2c_wr_data),
    .i2c_end(i2c_end), .i2c_rd_data(i2c_rd_data), .busy(busy)
  );

  always @(negedge sys_clk) begin
    if (i2c_start) start_cnt++;
    if (req0_ack) ack_log.push_back(0);
    if (req1_ack) ack_log.push_back(1);
  end

  typedef struct {
    logic rst, v0, rw0; logic [7:0] a0, d0;
    logic v1, rw1; logic [7:0] a1, d1;
    logic e; logic [7:0] rd;
    logic [30:0] exp;
  } vec_t;

  vec_t vt[15];

  function automatic logic [30:0] ex(logic a0, logic a1, logic [7:0] rdat, logic err,
                                     logic st, logic wr, logic rd, logic [7:0] ad,
                                     logic [7:0] wd, logic bz);
    return {a0, a1, rdat, err, st, wr, rd, ad, wd, bz};
  endfunction

  function automatic vec_t mk(logic rst, logic v0, logic rw0, logic [7:0] a0, logic [7:0] d0,
                              logic v1, logic rw1, logic [7:0] a1, logic [7:0] d1,
                              logic e, logic [7:0] rd, logic [30:0] exp);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.rw0 = rw0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.rw1 = rw1; v.a1 = a1; v.d1 = d1; v.e = e; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  function automatic logic [30:0] outs();
    return {req0_ack, req1_ack, rsp_rdata, rsp_err, i2c_start, i2c_wr_en, i2c_rd_en,
            i2c_byte_addr, i2c_wr_data, busy};
  endfunction

  task automatic chk(input string nm, input logic [30:0] act, input logic [30:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sys_rst = v.rst;
    req0_valid = v.v0; req0_rw = v.rw0; req0_addr = v.a0; req0_wdata = v.d0;
    req1_valid = v.v1; req1_rw = v.rw1; req1_addr = v.a1; req1_wdata = v.d1;
    i2c_end = v.e; i2c_rd_data = v.rd;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; i2c_end = 1'b0;
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    int base, n, k, ab;
    logic busy_ok, in_range;

    vt[0]  = mk(1, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,8'h00, ex(0,0,8'h00,0,0,0,0,8'h00,8'h00,0));
    vt[1]  = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,8'h00, ex(0,0,8'h00,0,0,0,0,8'h00,8'h00,0));
    vt[2]  = mk(0, 0,0,8'h00,8'h00, 1,1,8'h0A,8'h00, 0,8'h00, ex(0,0,8'h00,0,1,0,1,8'h0A,8'h00,1));
    vt[3]  = mk(0, 0,0,8'h00,8'h00, 1,1,8'h0A,8'h00, 0,8'h00, ex(0,0,8'h00,0,0,0,1,8'h0A,8'h00,1));
    vt[4]  = mk(0, 0,0,8'h00,8'h00, 1,1,8'h0A,8'h00, 1,8'h56, ex(0,1,8'h56,0,0,0,1,8'h0A,8'h00,1));
    vt[5]  = mk(0, 0,0,8'h00,8'h00, 1,1,8'h0A,8'h00, 1,8'h77, ex(0,0,8'h00,0,0,0,0,8'h00,8'h00,0));
    vt[6]  = mk(0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 1,8'h99, ex(0,0,8'h00,0,0,0,0,8'h00,8'h00,0));
    vt[7]  = mk(0, 1,0,8'h30,8'h08, 1,0,8'h11,8'h22, 0,8'h00, ex(0,0,8'h00,0,1,1,0,8'h30,8'h08,1));
    vt[8]  = mk(0, 1,0,8'hFF,8'h00, 1,0,8'h11,8'h22, 0,8'h00, ex(0,0,8'h00,0,0,1,0,8'h30,8'h08,1));
    vt[9]  = mk(0, 1,0,8'hFF,8'h00, 1,0,8'h11,8'h22, 1,8'hAB, ex(1,0,8'h00,0,0,1,0,8'h30,8'h08,1));
    vt[10] = mk(0, 0,0,8'h00,8'h00, 1,0,8'h11,8'h22, 0,8'h00, ex(0,0,8'h00,0,0,0,0,8'h00,8'h00,0));
    vt[11] = mk(0, 0,0,8'h00,8'h00, 1,0,8'h11,8'h22, 0,8'h00, ex(0,0,8'h00,0,1,1,0,8'h11,8'h22,1));
    vt[12] = mk(0, 0,0,8'h00,8'h00, 1,0,8'h11,8'h22, 1,8'h33, ex(0,0,8'h00,0,0,1,0,8'h11,8'h22,1));
    vt[13] = mk(0, 0,0,8'h00,8'h00, 1,0,8'h11,8'h22, 1,8'h44, ex(0,1,8'h00,0,0,1,0,8'h11,8'h22,1));
    vt[14] = mk(0, 0,0,8'h00,8'h00, 0,0,8'h11,8'h22, 0,8'h00, ex(0,0,8'h00,0,0,0,0,8'h00,8'h00,0));

    drive(vt[0]);
    for (int i = 0; i < 15; i++) begin
      drive(vt[i]);
      tick();
      chk($sformatf("vec%0d", i), outs(), vt[i].exp);
    end

    // Single write, i2c_end 40 cycles after the start pulse.
    do_reset();
    base = start_cnt; ab = ack_log.size();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 8'h30; req0_wdata = 8'h08;
    tick();
    chk("wr_start", {i2c_start, i2c_wr_en, i2c_rd_en, i2c_byte_addr, i2c_wr_data},
        {1'b1, 1'b1, 1'b0, 8'h30, 8'h08});
    for (int c = 0; c < 39; c++) tick();
    i2c_end = 1'b1;
    tick();
    i2c_end = 1'b0;
    req0_valid = 1'b0;
    chk("wr_ack", {req0_ack, req1_ack, rsp_err}, 3'b100);
    tick();
    chk("wr_ack_one_cycle", {req0_ack, busy}, 2'b00);
    chk("wr_start_count", start_cnt - base, 1);
    chk("wr_ack_count", ack_log.size() - ab, 1);

    // Both requesters held valid: grants must alternate starting with req0.
    do_reset();
    base = start_cnt; ab = ack_log.size();
    req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 8'h01; req0_wdata = 8'h10;
    req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 8'h02; req1_wdata = 8'h20;
    n = 0;
    for (int c = 0; c < 400 && n < 4; c++) begin
      tick();
      if (req0_ack || req1_ack) begin
        n++;
        if (n == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
      end
      i2c_end = busy && !i2c_start && !req0_ack && !req1_ack;
    end
    i2c_end = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("rr_ack_total", n, 4);
    chk("rr_start_count", start_cnt - base, 4);
    if (ack_log.size() - ab >= 4)
      for (int j = 0; j < 4; j++)
        chk($sformatf("rr_order%0d", j), ack_log[ab + j], j % 2);

    // Reset while BUSY aborts silently.
    do_reset();
    ab = ack_log.size();
    req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 8'h44; req0_wdata = 8'h00;
    tick(); tick(); tick();
    chk("pre_rst_busy", busy, 1'b1);
    sys_rst = 1'b1; req0_valid = 1'b0;
    tick();
    sys_rst = 1'b0;
    chk("rst_outputs", outs(), 31'd0);
    tick();
    i2c_end = 1'b1; i2c_rd_data = 8'hEE;
    tick();
    i2c_end = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("rst_no_ack", ack_log.size() - ab, 0);
    chk("rst_idle", busy, 1'b0);

    // Missing i2c_end.
    do_reset();
    ab = ack_log.size();
    req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 8'h5A; req1_wdata = 8'h00;
    tick();
    chk("tmo_start", i2c_start, 1'b1);
`ifdef SCCB_ARB_TIMEOUT_EN
    k = 0;
    while (k < 300 && !req1_ack) begin
      tick();
      k++;
    end
    req1_valid = 1'b0;
    in_range = (k >= 100 && k <= 101);
    chk("tmo_latency_in_range", in_range, 1'b1);
    chk("tmo_rsp", {req1_ack, rsp_err, rsp_rdata}, {1'b1, 1'b1, 8'h00});
    tick();
`else
    busy_ok = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (!busy) busy_ok = 1'b0;
    end
    chk("hang_busy", busy_ok, 1'b1);
    chk("hang_no_ack", ack_log.size() - ab, 0);
    req1_valid = 1'b0;
    do_reset();
    tick();
    chk("hang_reset_idle", busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/sccb_arb.md
SCCB_ARB -- requirements
Module: sccb_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 20'd500_000, number of sys_clk cycles allowed between i2c_start and i2c_end.
REQ-002 sys_clk  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 sys_rst  in  1  reset, synchronous, active-high.
REQ-004 req0_valid  in  1  requester 0 (init register sequencer) transaction request, level.
REQ-005 req0_rw  in  1  requester 0 direction: 0 write, 1 read.
REQ-006 req0_addr  in  8  requester 0 register byte address.
REQ-007 req0_wdata  in  8  requester 0 write data.
REQ-008 req0_ack  out  1  requester 0 completion, one-cycle pulse.
REQ-009 req1_valid, req1_rw, req1_addr, req1_wdata, req1_ack: same as REQ-004..008, for requester 1 (runtime exposure/white-balance writer).
REQ-010 rsp_rdata  out  8  read data of the completed transaction, valid while an ack is high.
REQ-011 rsp_err  out  1  completed transaction timed out, valid while an ack is high.
REQ-012 i2c_start  out  1  one-cycle trigger to the I2C master.
REQ-013 i2c_wr_en, i2c_rd_en  out  1 each  direction to the I2C master.
REQ-014 i2c_byte_addr  out  8, i2c_wr_data  out  8  address and data to the I2C master.
REQ-015 i2c_end  in  1  I2C master transaction complete, one-cycle pulse, sys_clk-synchronous.
REQ-016 i2c_rd_data  in  8  I2C master read data, valid with i2c_end.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, START, BUSY, DONE; all outputs registered.
REQ-019 IDLE: no valid -> stay; one valid -> grant it; both valid -> grant the requester not granted last (rr_last); after reset rr_last selects req0 on tie.
REQ-020 On grant: latch rw/addr/wdata of the winner into hold registers, record grant id, update rr_last, go START.
REQ-021 START: i2c_start = 1 for exactly this cycle; go BUSY.
REQ-022 i2c_byte_addr, i2c_wr_data, i2c_wr_en = ~rw, i2c_rd_en = rw driven from hold registers, stable from START through DONE; 0 in IDLE.
REQ-023 Requester input changes after grant do not affect the transaction in progress.
REQ-024 BUSY: on i2c_end go DONE; capture i2c_rd_data into rsp_rdata if rw = 1, else rsp_rdata = 8'h00; rsp_err = 0.
REQ-025 DONE: ack of the granted requester = 1 for this one cycle; other ack = 0; go IDLE.
REQ-026 Latency: valid sampled in IDLE at edge N -> i2c_start high cycle N+1; i2c_end at edge M -> ack high cycle M+1.
REQ-027 i2c_end arriving in IDLE, START or DONE is ignored.
REQ-028 Requester drops valid on the edge it samples its ack; valid still high in IDLE is a new request.
REQ-029 Back-to-back: both requesters continuously valid -> grants alternate 0,1,0,1.

Reset
REQ-030 sys_rst = 1 at an edge: state = IDLE, rr_last = req1 (so req0 wins first tie), hold registers = 0, all outputs = 0, timeout counter = 0; applies mid-transaction, no ack issued for the aborted transaction.

Configuration
REQ-031 Macro SCCB_ARB_TIMEOUT_EN defined: counter clears in START, increments each BUSY cycle; reaching TIMEOUT_CYC without i2c_end -> go DONE with rsp_err = 1, rsp_rdata = 8'h00.
REQ-032 Macro SCCB_ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely for i2c_end; rsp_err constant 0; TIMEOUT_CYC unused.

Verification
REQ-033 req0 write addr 8'h30 data 8'h08, i2c_end 40 cycles after i2c_start -> one i2c_start pulse, i2c_byte_addr 8'h30, i2c_wr_data 8'h08, i2c_wr_en 1, req0_ack one cycle later, rsp_err 0.
REQ-034 req1 read addr 8'h0A, i2c_end with i2c_rd_data 8'h56 -> i2c_rd_en 1, req1_ack with rsp_rdata 8'h56.
REQ-035 req0 and req1 valid in same cycle after reset, held for 4 transactions -> grant order 0,1,0,1; exactly 4 i2c_start pulses.
REQ-036 SCCB_ARB_TIMEOUT_EN defined, TIMEOUT_CYC = 100, i2c_end never -> ack 100..101 cycles after i2c_start, rsp_err 1, rsp_rdata 8'h00; undefined -> busy stays 1 for 10000 cycles, no ack.
REQ-037 sys_rst pulsed one cycle while BUSY -> next cycle all outputs 0, busy 0, no ack; a later i2c_end produces no ack.
REQ-038 i2c_end pulsed while IDLE, and req0_addr changed from 8'h30 to 8'hFF during BUSY -> no ack from the stray pulse; i2c_byte_addr stays 8'h30.
